// File: rtl/m72_pkg.sv
// Shared definitions for the M72 background-layer SDRAM path.
// Contents:
//   SDR_ADDR_W / SDR_DATA_W - SDRAM word address and data widths.
//   arb_state_t             - channel arbiter state encoding.
//   layer_t                 - identifies which background layer owns the channel.
//   pick_layer()            - grant selection for one arbitration decision.
package m72_pkg;

  localparam int SDR_ADDR_W = 25;
  localparam int SDR_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    LAYER_A = 1'b0,
    LAYER_B = 1'b1
  } layer_t;

  // A lone requester always wins. Under contention, round-robin hands the
  // channel to whichever layer was not served last; fixed priority favours A.
  function automatic layer_t pick_layer(input logic   req_a,
                                        input logic   req_b,
                                        input layer_t last,
                                        input logic   round_robin);
    layer_t sel;
    sel = LAYER_A;
    if (req_a && req_b) begin
      if (round_robin && (last == LAYER_A)) begin
        sel = LAYER_B;
      end
    end else if (req_b) begin
      sel = LAYER_B;
    end
    return sel;
  endfunction

endpackage

// File: rtl/bg_sdr_arbiter.sv
// Shares one SDRAM read channel between the two background layers (A and B)
// of the B-D board. One transaction is in flight at a time:
//   IDLE -> (grant) -> WAIT -> (sdr_ack) -> RESP -> IDLE
// Ports:
//   CLK_32M           system clock, all logic on its rising edge
//   RESET             synchronous, active-high; overrides everything
//   req_a / addr_a    layer A fetch request (level) and SDRAM word address
//   ack_a / data_a    layer A one-cycle completion pulse and fetched data
//   req_b .. data_b   same for layer B
//   sdr_req/sdr_addr  request level and address to the SDRAM channel
//   sdr_ack/sdr_data  channel completion strobe and read data (same cycle)
//   busy              high whenever the arbiter is not in IDLE
// Parameter:
//   ROUND_ROBIN       1 = alternate under contention, 0 = layer A always wins
module bg_sdr_arbiter
  import m72_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  CLK_32M,
  input  logic                  RESET,
  input  logic                  req_a,
  input  logic [SDR_ADDR_W-1:0] addr_a,
  output logic                  ack_a,
  output logic [SDR_DATA_W-1:0] data_a,
  input  logic                  req_b,
  input  logic [SDR_ADDR_W-1:0] addr_b,
  output logic                  ack_b,
  output logic [SDR_DATA_W-1:0] data_b,
  output logic                  sdr_req,
  output logic [SDR_ADDR_W-1:0] sdr_addr,
  input  logic                  sdr_ack,
  input  logic [SDR_DATA_W-1:0] sdr_data,
  output logic                  busy
);

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  arb_state_t state;
  layer_t     grant;
  layer_t     last_grant;
  layer_t     next_grant;

  always_comb begin
    next_grant = pick_layer(req_a, req_b, last_grant, RR_EN);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state      <= ST_IDLE;
      grant      <= LAYER_A;
      // Pretend B was served last so A takes the first contended grant.
      last_grant <= LAYER_B;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      data_a     <= '0;
      data_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Grant, address capture and sdr_req all land on the same edge.
          if (req_a || req_b) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            sdr_addr   <= (next_grant == LAYER_B) ? addr_b : addr_a;
            sdr_req    <= 1'b1;
            state      <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // The transaction runs to completion even if the requester has
          // since dropped req_x; sdr_addr is frozen until the ack.
          if (sdr_ack) begin
            sdr_req <= 1'b0;
            state   <= ST_RESP;
            if (grant == LAYER_B) begin
              data_b <= sdr_data;
              ack_b  <= 1'b1;
            end else begin
              data_a <= sdr_data;
              ack_a  <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          // One turnaround cycle lets the requester drop its level before
          // the next arbitration in IDLE.
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bg_sdr_arbiter.sv
// Bench for bg_sdr_arbiter. Two instances share every input: index 0 uses
// round-robin, index 1 fixed priority. Their state timing is identical, so
// both are checked at every step, each against its own expected grant.
module tb_bg_sdr_arbiter;
  import m72_pkg::*;

  logic        CLK_32M = 1'b0;
  logic        RESET;
  logic        req_a, req_b, sdr_ack;
  logic [24:0] addr_a, addr_b;
  logic [31:0] sdr_data;

  logic [1:0]  ack_a_v, ack_b_v, sdr_req_v, busy_v;
  logic [31:0] data_a_v [2];
  logic [31:0] data_b_v [2];
  logic [24:0] sdr_addr_v [2];

  always #5 CLK_32M = ~CLK_32M;

  bg_sdr_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .CLK_32M(CLK_32M), .RESET(RESET),
    .req_a(req_a), .addr_a(addr_a), .ack_a(ack_a_v[0]), .data_a(data_a_v[0]),
    .req_b(req_b), .addr_b(addr_b), .ack_b(ack_b_v[0]), .data_b(data_b_v[0]),
    .sdr_req(sdr_req_v[0]), .sdr_addr(sdr_addr_v[0]),
    .sdr_ack(sdr_ack), .sdr_data(sdr_data), .busy(busy_v[0])
  );

  bg_sdr_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .CLK_32M(CLK_32M), .RESET(RESET),
    .req_a(req_a), .addr_a(addr_a), .ack_a(ack_a_v[1]), .data_a(data_a_v[1]),
    .req_b(req_b), .addr_b(addr_b), .ack_b(ack_b_v[1]), .data_b(data_b_v[1]),
    .sdr_req(sdr_req_v[1]), .sdr_addr(sdr_addr_v[1]),
    .sdr_ack(sdr_ack), .sdr_data(sdr_data), .busy(busy_v[1])
  );

  // exp_rr / exp_fp: 0 = layer A granted, 1 = layer B granted.
  typedef struct {
    logic        ra;
    logic        rb;
    logic [24:0] aa;
    logic [24:0] ab;
    logic [31:0] d;
    int          lat;
    logic        exp_rr;
    logic        exp_fp;
    logic        drop_b;
    logic        spur_resp;
  } vec_t;

  typedef struct {
    int          dut;
    logic        layer;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs [10];
  sb_t         sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_da [2];
  logic [31:0] model_db [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_sdr_req"}, 64'(sdr_req_v[d]), 64'(0));
      chk({tag, "_busy"},    64'(busy_v[d]),    64'(0));
      chk({tag, "_ack_a"},   64'(ack_a_v[d]),   64'(0));
      chk({tag, "_ack_b"},   64'(ack_b_v[d]),   64'(0));
      chk({tag, "_data_a"},  64'(data_a_v[d]),  64'(model_da[d]));
      chk({tag, "_data_b"},  64'(data_b_v[d]),  64'(model_db[d]));
    end
  endtask

  // Starts and ends with the arbiters in IDLE, sampled at a falling edge.
  task automatic run_txn(input vec_t v, input string tag);
    logic        exp_l [2];
    logic [24:0] ea    [2];
    sb_t         s;
    exp_l[0] = v.exp_rr;
    exp_l[1] = v.exp_fp;
    req_a  = v.ra;
    req_b  = v.rb;
    addr_a = v.aa;
    addr_b = v.ab;
    for (int d = 0; d < 2; d++) ea[d] = exp_l[d] ? v.ab : v.aa;

    @(negedge CLK_32M);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_grant_req"},  64'(sdr_req_v[d]),  64'(1));
      chk({tag, "_grant_busy"}, 64'(busy_v[d]),     64'(1));
      chk({tag, "_grant_addr"}, 64'(sdr_addr_v[d]), 64'(ea[d]));
    end
    if (v.drop_b) req_b = 1'b0;
    addr_a = 25'($urandom);
    addr_b = 25'($urandom);

    for (int i = 1; i < v.lat; i++) begin
      @(negedge CLK_32M);
      for (int d = 0; d < 2; d++) begin
        chk({tag, "_wait_req"},  64'(sdr_req_v[d]),  64'(1));
        chk({tag, "_wait_addr"}, 64'(sdr_addr_v[d]), 64'(ea[d]));
        chk({tag, "_wait_ack"},  64'({ack_a_v[d], ack_b_v[d]}), 64'(0));
      end
      addr_a = 25'($urandom);
      addr_b = 25'($urandom);
    end

    sdr_ack  = 1'b1;
    sdr_data = v.d;
    for (int d = 0; d < 2; d++) sb.push_back('{dut: d, layer: exp_l[d], data: v.d});

    @(negedge CLK_32M);
    sdr_ack = 1'b0;
    if (v.spur_resp) begin
      sdr_ack  = 1'b1;
      sdr_data = ~v.d;
    end
    for (int d = 0; d < 2; d++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_underflow"}, 64'(1), 64'(0));
      end else begin
        s = sb.pop_front();
        if (s.layer) model_db[s.dut] = s.data;
        else         model_da[s.dut] = s.data;
        chk({tag, "_ack_a"},    64'(ack_a_v[s.dut]),  64'(!s.layer));
        chk({tag, "_ack_b"},    64'(ack_b_v[s.dut]),  64'(s.layer));
        chk({tag, "_resp_req"}, 64'(sdr_req_v[s.dut]), 64'(0));
        chk({tag, "_resp_busy"},64'(busy_v[s.dut]),   64'(1));
        chk({tag, "_data_a"},   64'(data_a_v[s.dut]), 64'(model_da[s.dut]));
        chk({tag, "_data_b"},   64'(data_b_v[s.dut]), 64'(model_db[s.dut]));
      end
    end

    @(negedge CLK_32M);
    sdr_ack = 1'b0;
    chk_idle({tag, "_after"});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 25'h0AAAAAA, 25'h1555555, 32'h11110000, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 25'h0AAAAAA, 25'h1555555, 32'h22220001, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 25'h0AAAAAA, 25'h1555555, 32'h33330002, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 25'h0AAAAAA, 25'h1555555, 32'h44440003, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 25'h0123456, 25'h1FFFFFF, 32'hDEADBEEF, 5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 25'h0000001, 25'h1000000, 32'h0BADF00D, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 25'h1FFFFFF, 25'h0000000, 32'hCAFEF00D, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 25'h0000000, 25'h0000000, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 25'h0000100, 25'h0000200, 32'h5A5A5A5A, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 25'h0000100, 25'h0000200, 32'hA5A5A5A5, 6, 1'b1, 1'b0, 1'b0, 1'b0};

    RESET    = 1'b1;
    req_a    = 1'b0;
    req_b    = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    sdr_ack  = 1'b0;
    sdr_data = '0;
    for (int d = 0; d < 2; d++) begin
      model_da[d] = '0;
      model_db[d] = '0;
    end

    repeat (3) @(negedge CLK_32M);
    chk_idle("reset");
    for (int d = 0; d < 2; d++) chk("reset_sdr_addr", 64'(sdr_addr_v[d]), 64'(0));
    RESET = 1'b0;
    @(negedge CLK_32M);
    chk_idle("post_reset");

    // Spurious strobe while IDLE.
    sdr_ack  = 1'b1;
    sdr_data = 32'h12345678;
    @(negedge CLK_32M);
    sdr_ack = 1'b0;
    chk_idle("spur_idle");
    for (int d = 0; d < 2; d++) chk("spur_idle_addr", 64'(sdr_addr_v[d]), 64'(0));

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge CLK_32M);
    chk_idle("drained");

    // Reset mid-WAIT, coinciding with an ack, followed by a stray late ack.
    req_a  = 1'b1;
    addr_a = 25'h0777777;
    @(negedge CLK_32M);
    for (int d = 0; d < 2; d++) chk("rst_wait_req", 64'(sdr_req_v[d]), 64'(1));
    @(negedge CLK_32M);
    RESET    = 1'b1;
    req_a    = 1'b0;
    sdr_ack  = 1'b1;
    sdr_data = 32'hFEEDFACE;
    @(negedge CLK_32M);
    RESET = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_da[d] = '0;
      model_db[d] = '0;
      chk("rst_mid_addr", 64'(sdr_addr_v[d]), 64'(0));
    end
    chk_idle("rst_mid");
    @(negedge CLK_32M);
    sdr_ack = 1'b0;
    chk_idle("stray_ack");

    // After reset A must win contention, even though round-robin last served A.
    run_txn('{1'b1, 1'b1, 25'h0ABCDEF, 25'h1234567, 32'h600DF00D, 2, 1'b0, 1'b0, 1'b0, 1'b0},
            "post_rst_contend");

    chk("sb_leftover", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
